// File: rtl/adder_pipe.sv
// ---------------------------------------------------------------------------
// adder_pipe
//
// Pipelined add/subtract unit. The carry chain is cut into chunks of
// g_chunk_width bits, and each pipeline stage resolves one chunk. This lets
// wide operands close timing while still producing one result per cycle.
//
// Parameters
//   g_data_width   operand width W (>= 1)
//   g_chunk_width  carry-chain bits resolved per stage C (1..W)
//   N = ceil(W/C)  number of stages (derived). The top chunk may be narrower.
//
// Ports
//   i_clk    clock, everything on the rising edge
//   i_rst    asynchronous active-high reset
//   i_valid  input transaction valid
//   o_ready  unit accepts an input this cycle (global pipeline enable)
//   i_A      operand A, unsigned, W bits
//   i_B      operand B, unsigned, W bits
//   i_sub    0 = A+B, 1 = A-B, sampled with the operands
//   o_valid  result valid
//   i_ready  downstream accepts the result
//   o_C      result, W+1 bits (add: zero-extended sum, sub: two's complement)
// ---------------------------------------------------------------------------
module adder_pipe #(
    parameter int g_data_width  = 16,
    parameter int g_chunk_width = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [g_data_width-1:0] i_A,
    input  logic [g_data_width-1:0] i_B,
    input  logic                    i_sub,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [g_data_width:0]   o_C
);

    localparam int W = g_data_width;
    localparam int C = g_chunk_width;
    localparam int N = (W + C - 1) / C;

    // Per-stage state. Stage k holds the result of resolving chunk k:
    // the sum bits resolved so far, the carry out of chunk k, the still
    // unprocessed upper bits of A and of the (possibly inverted) B, and
    // the mode bit needed to form the final top bit.
    logic [N-1:0] valid_q, valid_d;
    logic [N-1:0] sub_q,   sub_d;
    logic [N-1:0] carry_q, carry_d;
    logic [W-1:0] a_q   [N];
    logic [W-1:0] a_d   [N];
    logic [W-1:0] b_q   [N];
    logic [W-1:0] b_d   [N];
    logic [W-1:0] sum_q [N];
    logic [W-1:0] sum_d [N];

    logic en;

    // Global stall: the whole pipe advances unless a finished result is
    // sitting at the output and the consumer refuses it. An empty output
    // register therefore never blocks the pipe.
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    // Next-state for every stage. Stage 0 takes its inputs from the ports
    // (subtraction is A + ~B + 1, so B is inverted and the mode bit becomes
    // the initial carry); later stages take them from the previous stage.
    // Inside each stage the chunk is a plain bit ripple, and bits that
    // have been consumed are cleared so only upper chunks travel onward.
    always_comb begin
        logic [W-1:0] src_a;
        logic [W-1:0] src_b;
        logic [W-1:0] src_sum;
        logic         src_valid;
        logic         src_sub;
        logic         carry;

        for (int k = 0; k < N; k++) begin
            src_a     = '0;
            src_b     = '0;
            src_sum   = '0;
            src_valid = 1'b0;
            src_sub   = 1'b0;
            carry     = 1'b0;

            if (k == 0) begin
                src_valid = i_valid;
                if (i_valid) begin
                    src_sub = i_sub;
                    src_a   = i_A;
                    src_b   = i_sub ? ~i_B : i_B;
                    carry   = i_sub;
                end
            end else begin
                src_valid = valid_q[k-1];
                src_sub   = sub_q[k-1];
                src_a     = a_q[k-1];
                src_b     = b_q[k-1];
                src_sum   = sum_q[k-1];
                carry     = carry_q[k-1];
            end

            for (int p = 0; p < W; p++) begin
                if ((p / C) == k) begin
                    src_sum[p] = src_a[p] ^ src_b[p] ^ carry;
                    carry      = (src_a[p] & src_b[p]) | (carry & (src_a[p] ^ src_b[p]));
                    src_a[p]   = 1'b0;
                    src_b[p]   = 1'b0;
                end
            end

            valid_d[k] = src_valid;
            sub_d[k]   = src_sub;
            carry_d[k] = carry;
            a_d[k]     = src_a;
            b_d[k]     = src_b;
            sum_d[k]   = src_sum;
        end
    end

    // Stage registers. Reset clears everything at once so no in-flight
    // result can survive; when stalled every stage simply holds, bubbles
    // included.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= '0;
            sub_q   <= '0;
            carry_q <= '0;
            for (int k = 0; k < N; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (en) begin
            valid_q <= valid_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            for (int k = 0; k < N; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    // The last stage is the output register. In subtract mode the top bit
    // is the inverted carry: a carry out means A >= B, i.e. non-negative.
    assign o_valid = valid_q[N-1];
    assign o_C     = {carry_q[N-1] ^ sub_q[N-1], sum_q[N-1]};

`ifdef USE_VERILATOR
    // Shift register of accepts that have seen an unstalled pipe every
    // cycle since; when a token reaches the last slot the result must be
    // on the output.
    logic [N-1:0] acc_hist_q;
    int unsigned  stall_len_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_hist_q  <= '0;
            stall_len_q <= 0;
        end else begin
            acc_hist_q[0] <= i_valid && o_ready;
            for (int k = 1; k < N; k++) begin
                acc_hist_q[k] <= acc_hist_q[k-1] && en;
            end
            stall_len_q <= (o_valid && !i_ready) ? stall_len_q + 1 : 0;
        end
    end

    a_stall_hold: assert property (@(posedge i_clk) disable iff (i_rst)
        o_valid && !i_ready |=> $stable(o_C) && o_valid);

    a_add_max: assert property (@(posedge i_clk) disable iff (i_rst)
        o_valid && !sub_q[N-1] |-> o_C <= {{W{1'b1}}, 1'b0});

    a_latency: assert property (@(posedge i_clk) disable iff (i_rst)
        acc_hist_q[N-1] |-> o_valid);

    c_sub_negative: cover property (@(posedge i_clk) disable iff (i_rst)
        o_valid && sub_q[N-1] && o_C[W]);

    c_stall_3: cover property (@(posedge i_clk) disable iff (i_rst)
        stall_len_q >= 3);
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_adder_pipe
//
// Directed bench for adder_pipe (W=16, C=4, so four stages). Inputs are
// driven just after the falling edge; outputs are inspected 1 ns later,
// well away from the rising edge. Every accepted transaction pushes its
// expected result onto a queue, and every consumed result pops and
// compares against it, so ordering, loss and duplication all show up.
// ---------------------------------------------------------------------------
module tb_adder_pipe;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = 4;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_A;
    logic [W-1:0] i_B;
    logic         i_sub;
    logic         o_valid;
    logic         i_ready;
    logic [W:0]   o_C;

    int checks = 0;
    int errors = 0;

    logic [W:0] sb [$];
    int         ncall       = 0;
    int         vcount      = 0;
    int         first_valid = -1;
    int         last_valid  = -1;
    bit         stalled_prev = 1'b0;
    logic [W:0] held_c;

    always #5 i_clk = ~i_clk;

    adder_pipe #(
        .g_data_width  (W),
        .g_chunk_width (C)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_A     (i_A),
        .i_B     (i_B),
        .i_sub   (i_sub),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_C     (o_C)
    );

    // Reference arithmetic on W+1 bits; subtraction wraps to two's complement.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W:0] ea;
        logic [W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return s ? (ea - eb) : (ea + eb);
    endfunction

    task automatic checkOutput(input string tag, input logic [W:0] observed, input logic [W:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then look at the
    // outputs for the coming rising edge and update the scoreboard.
    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic r, input bit has_exp, input logic [W:0] exp);
        logic [W:0] exp_val;
        @(negedge i_clk);
        ncall++;
        i_valid = v;
        i_A     = a;
        i_B     = b;
        i_sub   = s;
        i_ready = r;
        #1;
        if (stalled_prev) begin
            checkOutput("stall_valid_held", {{W{1'b0}}, o_valid}, 1);
            checkOutput("stall_data_held", o_C, held_c);
        end
        if (o_valid) begin
            vcount++;
            if (first_valid < 0) first_valid = ncall;
            last_valid = ncall;
        end
        if (o_valid && i_ready) begin
            if (sb.size() == 0) checkOutput("unexpected_result", {{W{1'b0}}, o_valid}, 0);
            else                checkOutput("result", o_C, sb.pop_front());
        end
        stalled_prev = o_valid && !i_ready;
        held_c       = o_C;
        if (v && o_ready) begin
            exp_val = has_exp ? exp : model(a, b, s);
            sb.push_back(exp_val);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        applyStimulus(1'b1, a, b, s, 1'b1, 1'b0, '0);
    endtask

    task automatic send_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [W:0] e);
        applyStimulus(1'b1, a, b, s, 1'b1, 1'b1, e);
    endtask

    task automatic idle(input logic r);
        applyStimulus(1'b0, '0, '0, 1'b0, r, 1'b0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1'b1);
        checkOutput("drain_empty", (W+1)'(sb.size()), 0);
        for (int i = 0; i < 4; i++) idle(1'b1);
    endtask

    initial begin
        int lat;
        int start_call;
        int v0;

        // Reset state
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_A     = '0;
        i_B     = '0;
        i_sub   = 1'b0;
        i_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        checkOutput("reset_o_valid", {{W{1'b0}}, o_valid}, 0);
        checkOutput("reset_o_C", o_C, 0);
        checkOutput("reset_o_ready", {{W{1'b0}}, o_ready}, 1);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Largest add and pipeline latency
        send_exp(16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            idle(1'b1);
            if (o_valid) begin
                lat = i;
                break;
            end
        end
        checkOutput("latency", (W+1)'(lat), N);
        checkOutput("ffff_plus_ffff", o_C, 17'h1FFFE);
        drain();

        // Carry ripple and subtraction corners, back to back
        send_exp(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        send_exp(16'h0000, 16'h0000, 1'b0, 17'h00000);
        send_exp(16'h0007, 16'h0005, 1'b1, 17'h00002);
        send_exp(16'h0005, 16'h0007, 1'b1, 17'h1FFFE);
        send_exp(16'h0000, 16'hFFFF, 1'b1, 17'h10001);
        send_exp(16'h0F0F, 16'h00F1, 1'b0, 17'h01000);
        drain();

        // Eight back-to-back accepts, alternating mode
        first_valid = -1;
        start_call  = ncall + 1;
        v0          = vcount;
        for (int i = 0; i < 8; i++) begin
            send(W'($urandom), W'($urandom), i[0]);
        end
        drain();
        checkOutput("burst_first_valid", (W+1)'(first_valid - start_call), N);
        checkOutput("burst_contiguous", (W+1)'(last_valid - first_valid), 7);
        checkOutput("burst_count", (W+1)'(vcount - v0), 8);

        // Three-cycle output stall with the producer still offering data
        for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom), i[1]);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, '0);
            checkOutput("stall_o_valid", {{W{1'b0}}, o_valid}, 1);
            checkOutput("stall_o_ready", {{W{1'b0}}, o_ready}, 0);
        end
        drain();

        // Reset with transactions in flight
        send(16'h1111, 16'h2222, 1'b0);
        send(16'h3333, 16'h0444, 1'b1);
        send(16'h0055, 16'h0066, 1'b1);
        idle(1'b1);
        @(posedge i_clk);
        #1;
        checkOutput("pre_reset_valid", {{W{1'b0}}, o_valid}, 1);
        i_rst = 1'b1;
        #1;
        checkOutput("async_reset_o_valid", {{W{1'b0}}, o_valid}, 0);
        checkOutput("async_reset_o_C", o_C, 0);
        sb.delete();
        stalled_prev = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            checkOutput("post_reset_quiet", {{W{1'b0}}, o_valid}, 0);
        end
        send_exp(16'h8000, 16'h8000, 1'b0, 17'h10000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
